fwrisc_wb_arbiter: RTL

Parametrised N-initiator Wishbone arbiter that merges several Wishbone initiator ports onto one initiator port. In the default configuration it merges an fwrisc core's instruction (wbi_) and data (wbd_) ports into a single bus master. The arbiter is selectable between fixed-priority and round-robin modes. A grant stays locked for the whole `cyc` tenure, and an optional bus-timeout watchdog terminates stalled cycles with `err`.

---
 rtl/fwrisc_wb_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fwrisc_wb_arbiter.sv
// Purpose : N-initiator Wishbone arbiter; fixed-priority or round-robin grant, locked per cyc tenure.
// Latency : request sampled in IDLE -> grant visible next cycle; response path (ack/err/dat_r) is combinational.
// Backpressure: ungranted channels simply wait (no ack); optional watchdog ends a stalled strobe with err.
//
// Ports:
//   clock, reset                 - sole clock, asynchronous active-high reset
//   wbt_*  (N packed channels)   - upstream initiator ports, channel k at [k*W +: W]
//   wbi_*                        - merged downstream initiator port
module fwrisc_wb_arbiter #(
  parameter int N_INITIATORS   = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [N_INITIATORS*ADDR_WIDTH-1:0]      wbt_adr,
  input  logic [N_INITIATORS*DATA_WIDTH-1:0]      wbt_dat_w,
  output logic [N_INITIATORS*DATA_WIDTH-1:0]      wbt_dat_r,
  input  logic [N_INITIATORS-1:0]                 wbt_cyc,
  input  logic [N_INITIATORS-1:0]                 wbt_stb,
  input  logic [N_INITIATORS-1:0]                 wbt_we,
  input  logic [N_INITIATORS*(DATA_WIDTH/8)-1:0]  wbt_sel,
  output logic [N_INITIATORS-1:0]                 wbt_ack,
  output logic [N_INITIATORS-1:0]                 wbt_err,
  output logic [ADDR_WIDTH-1:0]                   wbi_adr,
  output logic [DATA_WIDTH-1:0]                   wbi_dat_w,
  input  logic [DATA_WIDTH-1:0]                   wbi_dat_r,
  output logic                                    wbi_cyc,
  output logic                                    wbi_stb,
  output logic                                    wbi_we,
  output logic [DATA_WIDTH/8-1:0]                 wbi_sel,
  input  logic                                    wbi_ack,
  input  logic                                    wbi_err
);

  localparam int N  = N_INITIATORS;
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The counter holds the number of stalled cycles already completed, so the
  // TIMEOUT_CYCLES-th stalled cycle is the one where the count is LIMIT-1.
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   last_gnt;
  logic [TW-1:0]   to_cnt;
  logic [TW-1:0]   to_cnt_nxt;

  logic [IW-1:0]   win_idx;
  logic            win_vld;
  int              k;

  logic [ADDR_WIDTH-1:0] g_adr;
  logic [DATA_WIDTH-1:0] g_dat_w;
  logic [SW-1:0]         g_sel;
  logic                  g_cyc;
  logic                  g_stb;
  logic                  g_we;

  logic act;
  logic timeout;

  // Winner search. Fixed mode scans from channel 0; round-robin scans upward
  // from the channel after the last grant, wrapping around.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      if (ARB_MODE == 1) k = (int'(last_gnt) + 1 + i) % N;
      else               k = i;
      if (!win_vld && wbt_cyc[k]) begin
        win_vld = 1'b1;
        win_idx = IW'(k);
      end
    end
  end

  // Granted channel fields, selected by the registered grant index.
  always_comb begin
    g_adr   = wbt_adr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    g_dat_w = wbt_dat_w[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    g_sel   = wbt_sel[int'(gnt_idx)*SW +: SW];
    g_cyc   = wbt_cyc[gnt_idx];
    g_stb   = wbt_stb[gnt_idx];
    g_we    = wbt_we[gnt_idx];
  end

  // Reset is folded in so outputs drop in the same cycle reset rises,
  // independent of how the async state clear propagates.
  assign act = (state == BUSY) && !reset;

  // Timeout fires on the strobe itself, not on the stall condition, so a
  // downstream ack arriving in that very cycle cannot rescue the transfer.
  assign timeout = (TIMEOUT_CYCLES > 0) && act && g_stb && (to_cnt == TO_LAST);

  always_comb begin
    to_cnt_nxt = to_cnt + TW'(1);
    if ((TIMEOUT_CYCLES == 0) || timeout || !g_stb || wbi_ack || wbi_err) begin
      to_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      last_gnt <= IW'(N - 1);
      to_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (win_vld) begin
            state    <= BUSY;
            gnt_idx  <= win_idx;
            last_gnt <= win_idx;
          end
        end
        BUSY: begin
          to_cnt <= to_cnt_nxt;
          // Release only on the owner dropping cyc; other requests wait for IDLE.
          if (!g_cyc) begin
            state  <= IDLE;
            to_cnt <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          to_cnt <= '0;
        end
      endcase
    end
  end

  // Downstream request mux; everything is zero while idle.
  always_comb begin
    wbi_adr   = '0;
    wbi_dat_w = '0;
    wbi_sel   = '0;
    wbi_we    = 1'b0;
    wbi_cyc   = 1'b0;
    wbi_stb   = 1'b0;
    if (act) begin
      wbi_adr   = g_adr;
      wbi_dat_w = g_dat_w;
      wbi_sel   = g_sel;
      wbi_we    = g_we;
      wbi_cyc   = g_cyc && !timeout;
      wbi_stb   = g_stb && !timeout;
    end
  end

  // Upstream response steering: only the granted channel sees ack/err.
  always_comb begin
    wbt_ack = '0;
    wbt_err = '0;
    if (act) begin
      wbt_ack[gnt_idx] = wbi_ack && !timeout;
      wbt_err[gnt_idx] = wbi_err || timeout;
    end
  end

  assign wbt_dat_r = reset ? '0 : {N{wbi_dat_r}};

endmodule
